// File: rtl/seq_divider.sv
// Multicycle signed restoring divider (MIPS DIV): quotient to lo, remainder to hi.
// Optional macro DIV_FAST_EXIT_EN: skip the iteration loop when |dividend| < |divisor|.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  // Handshake: start is sampled only in IDLE (busy=0); done (and div_zero when
  // divisor=0) pulses for exactly one cycle with hi/lo valid; hi/lo then hold.
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic [WIDTH-1:0]   div_q, div_d;
  logic               quot_neg_q, quot_neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               div_zero_q, div_zero_d;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     rem_shift, diff;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    div_d      = div_q;
    quot_neg_d = quot_neg_q;
    rem_neg_d  = rem_neg_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;

    mag_a     = dividend[WIDTH-1] ? -dividend : dividend;
    mag_b     = divisor[WIDTH-1]  ? -divisor  : divisor;
    // quot_q starts as |dividend| and shifts its MSB into the remainder each step.
    rem_shift = {rem_q, quot_q[WIDTH-1]};
    diff      = rem_shift - {1'b0, div_q};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            done_d     = 1'b1;
            div_zero_d = 1'b1;
          end else begin
            quot_neg_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            rem_neg_d  = dividend[WIDTH-1];
            div_d      = mag_b;
            rem_d      = '0;
            quot_d     = mag_a;
            cnt_d      = '0;
            state_d    = S_RUN;
`ifdef DIV_FAST_EXIT_EN
            if (mag_a < mag_b) begin
              rem_d   = mag_a;
              quot_d  = '0;
              state_d = S_FIX;
            end
`endif
          end
        end
      end
      S_RUN: begin
        if (!diff[WIDTH]) begin
          rem_d  = diff[WIDTH-1:0];
          quot_d = {quot_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d  = rem_shift[WIDTH-1:0];
          quot_d = {quot_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        lo_d    = quot_neg_q ? -quot_q : quot_q;
        hi_d    = rem_neg_q ? -rem_q : rem_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      div_q      <= '0;
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      div_q      <= div_d;
      quot_neg_q <= quot_neg_d;
      rem_neg_q  <= rem_neg_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
